// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Word-address width of the instruction ROM (1024 words = 4 KB).
    localparam int          IMEM_AW           = 10;
    localparam logic [31:0] IMEM_LIMIT        = 32'h0000_1000;
    localparam logic [31:0] LAST_WORD_PC      = IMEM_LIMIT - 32'd4;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // A fetch target is usable when it is word aligned and inside the 4 KB ROM.
    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc[31:12] == 20'h00000);
    endfunction

endpackage

// File: rtl/ifetch_unit_sat_counter.sv
// Saturating up-counter used for the fetch performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;
    logic             at_max_s;

    assign at_max_s = &count_r;

    // Count up on each inc pulse and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (inc && !at_max_s) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit driving a 1-cycle synchronous ROM, with
// stall replay, redirect, halt and sticky address-fault handling.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        fault_pc,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
);

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] instr_pc_r;
    logic [31:0] fault_pc_r;
    logic        valid_r;

    logic [31:0] next_pc_s;
    logic [31:0] seq_pc_s;
    logic [31:0] fault_target_s;
    logic        accept_s;
    logic        stall_inc_s;
    logic        replay_s;
    logic        halt_hit_s;
    logic        redirect_ok_s;
    logic        redirect_bad_s;
    logic        seq_overflow_s;
    logic        halted_s;
    logic        fault_s;

    // Decode the per-cycle handshake and exception conditions.
    always_comb begin
        accept_s       = valid_r & ~stall & ~redirect;
        stall_inc_s    = valid_r & stall & ~redirect;
        replay_s       = valid_r & stall & ~redirect;
        halt_hit_s     = accept_s & (imem_dout == HALT_WORD);
        redirect_ok_s  = redirect & pc_legal(redirect_pc);
        redirect_bad_s = redirect & ~pc_legal(redirect_pc);
        seq_pc_s       = instr_pc_r + 32'd4;
        // Only a real sequential advance past the last word faults.
        seq_overflow_s = ~redirect & ~replay_s & ~halt_hit_s
                         & (instr_pc_r == LAST_WORD_PC);
        fault_target_s = redirect_bad_s ? redirect_pc : seq_pc_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection; FAULT only leaves through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_bad_s) begin
                    state_next_s = ST_FAULT;
                end else if (redirect_ok_s) begin
                    state_next_s = ST_RUN;
                end else if (halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else if (seq_overflow_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect_bad_s) begin
                    state_next_s = ST_FAULT;
                end else if (redirect_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                state_next_s = ST_FAULT;
            end
        endcase
    end

    // Output decode: fetch address for the ROM plus status flags.
    always_comb begin
        next_pc_s = instr_pc_r;
        halted_s  = 1'b0;
        fault_s   = 1'b0;
        case (state_r)
            ST_BOOT: begin
                next_pc_s = RESET_PC;
            end
            ST_RUN: begin
                if (redirect) begin
                    next_pc_s = redirect_pc;
                end else if (replay_s || halt_hit_s) begin
                    // Re-read the same word so instr stays stable.
                    next_pc_s = instr_pc_r;
                end else begin
                    next_pc_s = seq_pc_s;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                if (redirect_ok_s) begin
                    next_pc_s = redirect_pc;
                end else begin
                    next_pc_s = instr_pc_r;
                end
            end
            ST_FAULT: begin
                fault_s   = 1'b1;
                next_pc_s = instr_pc_r;
            end
            default: begin
                fault_s   = 1'b1;
                next_pc_s = instr_pc_r;
            end
        endcase
    end

    // Presented-instruction address, valid flag and captured fault address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_pc_r <= RESET_PC;
            valid_r    <= 1'b0;
            fault_pc_r <= 32'h0000_0000;
        end else if (state_next_s == ST_FAULT) begin
            instr_pc_r <= instr_pc_r;
            valid_r    <= 1'b0;
            if (state_r != ST_FAULT) begin
                fault_pc_r <= fault_target_s;
            end else begin
                fault_pc_r <= fault_pc_r;
            end
        end else begin
            instr_pc_r <= next_pc_s;
            valid_r    <= (state_next_s == ST_RUN);
            fault_pc_r <= fault_pc_r;
        end
    end

    sat_counter #(.WIDTH(32)) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept_s),
        .count (fetch_count)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .count (stall_count)
    );

    assign imem_addr   = next_pc_s[IMEM_AW+1:2];
    assign instr       = imem_dout;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = valid_r;
    assign halted      = halted_s;
    assign fault       = fault_s;
    assign fault_pc    = fault_pc_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed table, corner sequences
// and randomized traffic against a behavioural fetch model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    logic [31:0] rom [0:1023];

    int n_checks;
    int n_errors;

    // Behavioural model state.
    bit          m_boot;
    bit          m_valid;
    bit          m_halted;
    bit          m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    ifetch_unit #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction ROM.
    always @(posedge clk) imem_dout <= rom[imem_addr];

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [31:0] efc;
        logic [31:0] esc;
        logic        eh;
        logic        ef;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_boot   = 1'b1;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        m_pc     = RESET_PC;
        m_fpc    = 32'h0;
        m_fc     = 32'h0;
        m_sc     = 32'h0;
    endtask

    // One clock of fetch behaviour written from the rules, not the RTL.
    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc);
        bit legal;
        legal = (rpc % 32'd4 == 32'd0) && (rpc < 32'h1000);
        if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
            m_pc    = RESET_PC;
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (m_halted) begin
            if (rd) begin
                m_halted = 1'b0;
                if (legal) begin
                    m_valid = 1'b1;
                    m_pc    = rpc;
                end else begin
                    m_fault = 1'b1;
                    m_fpc   = rpc;
                end
            end
        end else begin
            if (rd) begin
                if (legal) begin
                    m_pc = rpc;
                end else begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                    m_fpc   = rpc;
                end
            end else if (st) begin
                m_sc = sat_inc(m_sc);
            end else begin
                m_fc = sat_inc(m_fc);
                if (rom[m_pc / 4] == HALT_W) begin
                    m_halted = 1'b1;
                    m_valid  = 1'b0;
                end else if (m_pc + 32'd4 >= 32'h1000) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                    m_fpc   = m_pc + 32'd4;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk({tag, ".pc"}, instr_pc, m_pc);
            chk({tag, ".instr"}, instr, rom[m_pc / 4]);
        end
        chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halted});
        chk({tag, ".fault"}, {31'h0, fault}, {31'h0, m_fault});
        chk({tag, ".fault_pc"}, fault_pc, m_fpc);
        chk({tag, ".fetch_count"}, fetch_count, m_fc);
        chk({tag, ".stall_count"}, stall_count, m_sc);
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] hold_addr;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        if (m_halted && !m_fault && !rd) begin
            hold_addr = m_pc / 4;
            chk("halt_imem_addr", {22'h0, imem_addr}, hold_addr);
        end
        @(posedge clk);
        model_step(st, rd, rpc);
        #1;
    endtask

    task automatic do_reset();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rst_n       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_directed();
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0BAD_0000 + i;
    endtask

    initial begin
        bit got;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fill_directed();
        rom[20] = HALT_W;

        //             st    rd    rpc        ev    epc        ein           efc    esc    eh    ef
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 32'h0BAD0000, 32'd0,  32'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0BAD0001, 32'd1,  32'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0BAD0002, 32'd2,  32'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h0BAD0003, 32'd3,  32'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 32'h0BAD0004, 32'd4,  32'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h04, 32'h0BAD0001, 32'd4,  32'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0BAD0001, 32'd4,  32'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0BAD0001, 32'd4,  32'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0BAD0001, 32'd4,  32'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0BAD0002, 32'd5,  32'd3, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h04, 32'h0BAD0001, 32'd5,  32'd3, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 32'h0BAD0010, 32'd5,  32'd3, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 32'h0BAD0011, 32'd6,  32'd3, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h48, 32'h0BAD0012, 32'd7,  32'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4C, 32'h0BAD0013, 32'd8,  32'd3, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h50, 32'hFFFFFFFF, 32'd9,  32'd3, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0,        32'd10, 32'd3, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0,        32'd10, 32'd3, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 32'h0,  1'b1, 32'h00, 32'h0BAD0000, 32'd10, 32'd3, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0BAD0001, 32'd11, 32'd3, 1'b0, 1'b0};

        // Reset state before the first edge after release.
        do_reset();
        chk("rst.valid", {31'h0, instr_valid}, 32'h0);
        chk("rst.pc", instr_pc, RESET_PC);
        chk("rst.halted", {31'h0, halted}, 32'h0);
        chk("rst.fault", {31'h0, fault}, 32'h0);
        chk("rst.fault_pc", fault_pc, 32'h0);
        chk("rst.fetch_count", fetch_count, 32'h0);
        chk("rst.stall_count", stall_count, 32'h0);

        // Directed table: sequential, stall, stall+redirect, halt/resume.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].st, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("tbl%0d.valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d.pc", i), instr_pc, tbl[i].epc);
                chk($sformatf("tbl%0d.instr", i), instr, tbl[i].ein);
            end
            chk($sformatf("tbl%0d.fetch_count", i), fetch_count, tbl[i].efc);
            chk($sformatf("tbl%0d.stall_count", i), stall_count, tbl[i].esc);
            chk($sformatf("tbl%0d.halted", i), {31'h0, halted}, {31'h0, tbl[i].eh});
            chk($sformatf("tbl%0d.fault", i), {31'h0, fault}, {31'h0, tbl[i].ef});
        end

        // Halt on ROM[2], then resume at ROM[0].
        rom[2] = HALT_W;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("halt.instr", instr, HALT_W);
        chk("halt.pc", instr_pc, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("halt.halted", {31'h0, halted}, 32'h1);
        chk("halt.valid", {31'h0, instr_valid}, 32'h0);
        chk("halt.fetch_count", fetch_count, 32'd3);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        chk("resume.valid", {31'h0, instr_valid}, 32'h1);
        chk("resume.pc", instr_pc, 32'h0);
        chk("resume.instr", instr, 32'h0BAD0000);
        chk("resume.halted", {31'h0, halted}, 32'h0);
        rom[2] = 32'h0BAD0002;

        // Misaligned redirect faults; later redirects are ignored.
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h42);
        chk("flt42.fault", {31'h0, fault}, 32'h1);
        chk("flt42.fault_pc", fault_pc, 32'h42);
        chk("flt42.valid", {31'h0, instr_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        chk("flt42.sticky", {31'h0, fault}, 32'h1);
        chk("flt42.ignored", {31'h0, instr_valid}, 32'h0);
        chk("flt42.fault_pc_hold", fault_pc, 32'h42);

        // Sequential run off the end of the ROM.
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFF8);
        chk("end.pc_ff8", instr_pc, 32'hFF8);
        step(1'b0, 1'b0, 32'h0);
        chk("end.pc_ffc", instr_pc, 32'hFFC);
        chk("end.instr_ffc", instr, 32'h0BAD03FF);
        step(1'b0, 1'b0, 32'h0);
        chk("end.fault", {31'h0, fault}, 32'h1);
        chk("end.fault_pc", fault_pc, 32'h1000);
        step(1'b0, 1'b1, 32'h10);
        chk("end.sticky", {31'h0, fault}, 32'h1);
        chk("end.ignored", {31'h0, instr_valid}, 32'h0);

        // Out-of-range redirect (upper bits set).
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h2000);
        chk("flt2000.fault", {31'h0, fault}, 32'h1);
        chk("flt2000.fault_pc", fault_pc, 32'h2000);

        // Asynchronous reset mid-run with stall high.
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.valid", {31'h0, instr_valid}, 32'h0);
        chk("arst.pc", instr_pc, RESET_PC);
        chk("arst.fetch_count", fetch_count, 32'h0);
        chk("arst.stall_count", stall_count, 32'h0);
        chk("arst.halted", {31'h0, halted}, 32'h0);
        chk("arst.fault", {31'h0, fault}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 2 && !got; c++) begin
            step(1'b0, 1'b0, 32'h0);
            if (instr_valid) got = 1'b1;
        end
        chk("arst.first_valid", {31'h0, got}, 32'h1);
        chk("arst.first_pc", instr_pc, RESET_PC);
        chk("arst.first_instr", instr, rom[RESET_PC / 4]);

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 1024; i++) begin
            rom[i] = $urandom;
            if ($urandom_range(0, 39) == 0) rom[i] = HALT_W;
        end
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        st;
            logic        rd;
            logic [31:0] rpc;
            int          r;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 8) || (m_halted && $urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 19);
            if (r == 0) begin
                rpc = $urandom;
            end else if (r == 1) begin
                rpc = 32'h0000_1000 | ($urandom_range(0, 1023) * 4);
            end else if (r < 6) begin
                rpc = 32'hFF0 + $urandom_range(0, 3) * 4;
            end else begin
                rpc = $urandom_range(0, 1023) * 4;
            end
            step(st, rd, rpc);
            cmp_model("rand");
            if ((m_fault && $urandom_range(0, 5) == 0) || $urandom_range(0, 499) == 0) begin
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
